j1_code_loader: RTL and testbench

Boot-time code loader upstream of the j1 core's instruction memory. It receives a framed byte stream (typically from a UART receiver) and assembles 16-bit instruction words. It writes them sequentially into the code RAM that drives the core's insn input. The core is held in reset until a frame with a valid checksum has completed.

---
 rtl/j1_code_loader_if.sv | 25 ++
 rtl/j1_code_loader.sv | 125 ++++++++++++
 tb/tb_j1_code_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/j1_code_loader_if.sv
// rtl/j1_code_loader_if.sv - byte-stream, code-RAM write and core-control signals of the j1 code loader
interface j1_code_loader_if #(
  parameter int CODE_AW = 13
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               cram_we;
  logic [CODE_AW-1:0] cram_addr;
  logic [15:0]        cram_wdata;
  logic               core_resetq;
  logic               busy;
  logic               err;
  logic               load_req;

  modport master (
    input  rx_data, rx_valid, load_req,
    output rx_ready, cram_we, cram_addr, cram_wdata, core_resetq, busy, err
  );

  modport slave (
    output rx_data, rx_valid, load_req,
    input  rx_ready, cram_we, cram_addr, cram_wdata, core_resetq, busy, err
  );
endinterface

// File: rtl/j1_code_loader.sv
// rtl/j1_code_loader.sv - framed byte-stream boot loader filling the j1 code RAM
// Optional inter-byte gap timeout enabled by defining LOADER_TIMEOUT_EN.
module j1_code_loader #(
  parameter int         CODE_AW        = 13,
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             resetq,
  j1_code_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DLO, DHI, CSUM, RUN, ERROR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** CODE_AW);

  state_t      state, nxt;
  logic [15:0] len;
  logic [7:0]  lo_byte;
  logic [7:0]  csum;
  logic [16:0] wcnt;
  logic        acc;
  logic        last_word;
  logic        too_long;
  logic        zero_len;
  logic        timed_out;

  assign acc       = bus.rx_valid && bus.rx_ready;
  assign last_word = (wcnt + 17'd1) == {1'b0, len};
  // Full length is only known while LEN_HI is on the bus.
  assign too_long  = {1'b0, bus.rx_data, len[7:0]} > MAX_WORDS;
  assign zero_len  = {bus.rx_data, len[7:0]} == 16'd0;

`ifdef LOADER_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      gap <= '0;
    else if (!bus.busy || acc)
      gap <= '0;
    else
      gap <= gap + 1'b1;
  end

  assign timed_out = bus.busy && !acc && (gap == GW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    nxt = state;
    if (timed_out)
      nxt = ERROR;
    else begin
      case (state)
        IDLE, ERROR: if (acc && bus.rx_data == MAGIC) nxt = LEN0;
        LEN0:        if (acc) nxt = LEN1;
        LEN1:        if (acc) nxt = too_long ? ERROR : (zero_len ? CSUM : DLO);
        DLO:         if (acc) nxt = DHI;
        DHI:         if (acc) nxt = last_word ? CSUM : DLO;
        CSUM:        if (acc) nxt = (bus.rx_data == csum) ? RUN : ERROR;
        RUN:         if (bus.load_req) nxt = IDLE;
        default:     nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state           <= IDLE;
      bus.rx_ready    <= 1'b1;
      bus.cram_we     <= 1'b0;
      bus.cram_addr   <= '0;
      bus.cram_wdata  <= '0;
      bus.core_resetq <= 1'b0;
      bus.busy        <= 1'b0;
      bus.err         <= 1'b0;
      len             <= '0;
      lo_byte         <= '0;
      csum            <= '0;
      wcnt            <= '0;
    end else begin
      state           <= nxt;
      bus.rx_ready    <= (nxt != RUN);
      bus.busy        <= nxt inside {LEN0, LEN1, DLO, DHI, CSUM};
      bus.err         <= (nxt == ERROR);
      // Core leaves reset one cycle after RUN is entered, and re-enters it on load_req.
      bus.core_resetq <= (state == RUN) && (nxt == RUN);
      bus.cram_we     <= 1'b0;
      if (acc) begin
        case (state)
          IDLE, ERROR: wcnt <= '0;
          LEN0: begin
            len[7:0] <= bus.rx_data;
            csum     <= bus.rx_data;
          end
          LEN1: begin
            len[15:8] <= bus.rx_data;
            csum      <= csum ^ bus.rx_data;
          end
          DLO: begin
            lo_byte <= bus.rx_data;
            csum    <= csum ^ bus.rx_data;
          end
          DHI: begin
            csum           <= csum ^ bus.rx_data;
            bus.cram_we    <= 1'b1;
            bus.cram_addr  <= wcnt[CODE_AW-1:0];
            bus.cram_wdata <= {bus.rx_data, lo_byte};
            wcnt           <= wcnt + 17'd1;
          end
          default: ;
        endcase
      end
      if (state == RUN && bus.load_req) begin
        wcnt <= '0;
        len  <= '0;
        csum <= '0;
      end
    end
  end
endmodule

// File: tb/tb_j1_code_loader.sv
// tb/tb_j1_code_loader.sv - directed self-checking bench for j1_code_loader
module tb_j1_code_loader;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1000000;
`endif

  logic clk = 1'b0;
  logic resetq = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   nwr = 0;
  logic [12:0] wr_addr [16];
  logic [15:0] wr_data [16];
  logic [7:0]  q [$];

  always #5 clk = ~clk;

  j1_code_loader_if #(.CODE_AW(13)) bus ();

  j1_code_loader #(.CODE_AW(13), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus.master)
  );

  always @(negedge clk) begin
    if (bus.cram_we === 1'b1) begin
      if (nwr < 16) begin
        wr_addr[nwr] = bus.cram_addr;
        wr_data[nwr] = bus.cram_wdata;
      end
      nwr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the queued bytes back-to-back with rx_valid held high.
  task automatic send();
    int t;
    foreach (q[i]) begin
      t = 0;
      bus.rx_data  = q[i];
      bus.rx_valid = 1'b1;
      while (bus.rx_ready !== 1'b1 && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("rx_ready_in_frame", bus.rx_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    q.delete();
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(posedge clk);
    #1;
    bus.load_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.load_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_cram_we", bus.cram_we, 0);
    check("rst_cram_addr", bus.cram_addr, 0);
    check("rst_cram_wdata", bus.cram_wdata, 0);
    check("rst_core_resetq", bus.core_resetq, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    resetq = 1'b1;
    cycles(1);

    q = {8'h33};
    send();
    check("idle_discard_busy", bus.busy, 0);

    // Single word frame
    nwr = 0;
    q = {8'hA5, 8'h01, 8'h00, 8'h05, 8'h80, 8'h84};
    send();
    check("t1_nwr", nwr, 1);
    check("t1_addr", wr_addr[0], 13'h0000);
    check("t1_data", wr_data[0], 16'h8005);
    check("t1_core_rst_early", bus.core_resetq, 0);
    check("t1_busy", bus.busy, 0);
    cycles(1);
    check("t1_core_rst", bus.core_resetq, 1);
    check("t1_err", bus.err, 0);

    // RUN refuses bytes; load_req returns to IDLE
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    cycles(3);
    check("run_rx_ready", bus.rx_ready, 0);
    check("run_core_rst", bus.core_resetq, 1);
    check("run_busy", bus.busy, 0);
    bus.rx_valid = 1'b0;
    pulse_load();
    check("reload_core_rst", bus.core_resetq, 0);
    check("reload_rx_ready", bus.rx_ready, 1);

    // Two words back-to-back, writing from address 0 again
    nwr = 0;
    q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    send();
    check("t2_nwr", nwr, 2);
    check("t2_addr0", wr_addr[0], 13'h0000);
    check("t2_data0", wr_data[0], 16'h1234);
    check("t2_addr1", wr_addr[1], 13'h0001);
    check("t2_data1", wr_data[1], 16'h5678);
    cycles(1);
    check("t2_core_rst", bus.core_resetq, 1);

    // Bad checksum, then recovery
    pulse_load();
    nwr = 0;
    q = {8'hA5, 8'h01, 8'h00, 8'h05, 8'h80, 8'h00};
    send();
    check("bad_err", bus.err, 1);
    check("bad_core_rst", bus.core_resetq, 0);
    check("bad_rx_ready", bus.rx_ready, 1);
    cycles(2);
    check("bad_err_sticky", bus.err, 1);
    check("bad_core_rst_held", bus.core_resetq, 0);
    check("bad_write_kept", nwr, 1);
    q = {8'hA5};
    send();
    check("magic_clears_err", bus.err, 0);
    check("magic_busy", bus.busy, 1);
    q = {8'h01, 8'h00, 8'h05, 8'h80, 8'h84};
    send();
    cycles(1);
    check("recover_core_rst", bus.core_resetq, 1);
    check("recover_err", bus.err, 0);

    // Zero length
    pulse_load();
    nwr = 0;
    q = {8'hA5, 8'h00, 8'h00, 8'h00};
    send();
    cycles(1);
    check("zero_core_rst", bus.core_resetq, 1);
    check("zero_nwr", nwr, 0);

    // Oversize length 8193
    pulse_load();
    q = {8'hA5, 8'h01, 8'h20};
    send();
    check("over_err", bus.err, 1);
    check("over_busy", bus.busy, 0);
    check("over_core_rst", bus.core_resetq, 0);

    // Asynchronous reset after DLO
    q = {8'hA5, 8'h02, 8'h00, 8'h11};
    send();
    check("mid_busy", bus.busy, 1);
    nwr = 0;
    bus.rx_data  = 8'h22;
    bus.rx_valid = 1'b1;
    #2;
    resetq = 1'b0;
    #1;
    check("mid_rst_cram_we", bus.cram_we, 0);
    check("mid_rst_cram_addr", bus.cram_addr, 0);
    check("mid_rst_cram_wdata", bus.cram_wdata, 0);
    check("mid_rst_rx_ready", bus.rx_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_core_rst", bus.core_resetq, 0);
    cycles(3);
    check("mid_rst_nwr", nwr, 0);
    bus.rx_valid = 1'b0;
    resetq = 1'b1;
    cycles(1);

    // Stall after MAGIC
    q = {8'hA5};
    send();
    cycles(150);
`ifdef LOADER_TIMEOUT_EN
    check("stall_err", bus.err, 1);
    check("stall_busy", bus.busy, 0);
`else
    check("stall_err", bus.err, 0);
    check("stall_busy", bus.busy, 1);
    q = {8'h00, 8'h00, 8'h00};
    send();
    cycles(1);
    check("stall_core_rst", bus.core_resetq, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
